// File: rtl/tl_buffer_queue_pkg.sv
// Shared definitions for the TileLink-UL A/D channel buffer queue.
// Holds payload width functions, packed-field bit offsets and opcode constants.
// Payloads are packed MSB-first: opcode, param, size, source, ..., data, corrupt.
package tl_buffer_queue_pkg;

  localparam int SIZE_W = 4;
  localparam int SINK_W = 1;
  localparam int CNT_W  = 5;

  // A-channel opcodes
  localparam logic [2:0] A_PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] A_ARITHMETIC_DATA  = 3'd2;
  localparam logic [2:0] A_LOGICAL_DATA     = 3'd3;
  localparam logic [2:0] A_GET              = 3'd4;
  localparam logic [2:0] A_INTENT           = 3'd5;

  // D-channel opcodes
  localparam logic [2:0] D_ACCESS_ACK       = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA  = 3'd1;
  localparam logic [2:0] D_HINT_ACK         = 3'd2;

  // A payload: opcode(3) param(3) size source address mask data corrupt(1)
  function automatic int a_w(input int addr_w, input int data_w, input int source_w);
    return 3 + 3 + SIZE_W + source_w + addr_w + data_w / 8 + data_w + 1;
  endfunction

  // D payload: opcode(3) param(2) size source sink denied(1) data corrupt(1)
  function automatic int d_w(input int data_w, input int source_w);
    return 3 + 2 + SIZE_W + source_w + SINK_W + 1 + data_w + 1;
  endfunction

  // A field LSB offsets
  function automatic int a_corrupt_lsb();
    return 0;
  endfunction
  function automatic int a_data_lsb();
    return 1;
  endfunction
  function automatic int a_mask_lsb(input int data_w);
    return 1 + data_w;
  endfunction
  function automatic int a_address_lsb(input int data_w);
    return 1 + data_w + data_w / 8;
  endfunction
  function automatic int a_source_lsb(input int addr_w, input int data_w);
    return a_address_lsb(data_w) + addr_w;
  endfunction
  function automatic int a_size_lsb(input int addr_w, input int data_w, input int source_w);
    return a_source_lsb(addr_w, data_w) + source_w;
  endfunction
  function automatic int a_param_lsb(input int addr_w, input int data_w, input int source_w);
    return a_size_lsb(addr_w, data_w, source_w) + SIZE_W;
  endfunction
  function automatic int a_opcode_lsb(input int addr_w, input int data_w, input int source_w);
    return a_param_lsb(addr_w, data_w, source_w) + 3;
  endfunction

  // D field LSB offsets
  function automatic int d_corrupt_lsb();
    return 0;
  endfunction
  function automatic int d_data_lsb();
    return 1;
  endfunction
  function automatic int d_denied_lsb(input int data_w);
    return 1 + data_w;
  endfunction
  function automatic int d_sink_lsb(input int data_w);
    return 2 + data_w;
  endfunction
  function automatic int d_source_lsb(input int data_w);
    return d_sink_lsb(data_w) + SINK_W;
  endfunction
  function automatic int d_size_lsb(input int data_w, input int source_w);
    return d_source_lsb(data_w) + source_w;
  endfunction
  function automatic int d_param_lsb(input int data_w, input int source_w);
    return d_size_lsb(data_w, source_w) + SIZE_W;
  endfunction
  function automatic int d_opcode_lsb(input int data_w, input int source_w);
    return d_param_lsb(data_w, source_w) + 2;
  endfunction

endpackage

// File: rtl/tl_buffer_queue_queue.sv
// tl_queue: single-channel FIFO; DEPTH=0 is a wire-through with no state.
// Latency: 1 cycle minimum for DEPTH>=1 (no flow-through), 0 for DEPTH=0.
// Backpressure: enq ready = not full from registered count only; full refuses even on same-cycle dequeue.
// Optional high-water mark output when TL_BUFFER_QUEUE_STATS_EN is defined.
module tl_queue
  import tl_buffer_queue_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_valid_i,
  output logic             enq_ready_o,
  input  logic [WIDTH-1:0] enq_bits_i,
  output logic             deq_valid_o,
  input  logic             deq_ready_i,
  output logic [WIDTH-1:0] deq_bits_o,
  output logic [CNT_W-1:0] count_o
`ifdef TL_BUFFER_QUEUE_STATS_EN
  ,
  output logic [CNT_W-1:0] hwm_o
`endif
);

  if (DEPTH == 0) begin : g_bypass
    assign deq_valid_o = enq_valid_i;
    assign enq_ready_o = deq_ready_i;
    assign deq_bits_o  = enq_bits_i;
    assign count_o     = '0;
`ifdef TL_BUFFER_QUEUE_STATS_EN
    assign hwm_o       = '0;
`endif
    // Clock and reset have no load in the stateless bypass.
    logic unused_clk_rst;
    assign unused_clk_rst = clock ^ reset;
  end else begin : g_fifo
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_enq, do_deq;

    assign enq_ready_o = (count_q != FULL);
    assign deq_valid_o = (count_q != '0);
    assign deq_bits_o  = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign do_enq      = enq_valid_i & enq_ready_o;
    assign do_deq      = deq_valid_o & deq_ready_i;

    // Next pointers wrap LAST -> 0; count moves by enq minus deq.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(do_enq) - CNT_W'(do_deq);
      if (do_enq) begin
        wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_deq) begin
        rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
    end

    // Control state with synchronous active-low clear.
    always_ff @(posedge clock) begin
      if (!reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    // Payload storage is never cleared; only accepted beats are written.
    always_ff @(posedge clock) begin
      if (reset && do_enq) begin
        mem_q[wr_ptr_q] <= enq_bits_i;
      end
    end

`ifdef TL_BUFFER_QUEUE_STATS_EN
    logic [CNT_W-1:0] hwm_q, hwm_d;

    // Peak tracks the post-edge count, so it never lags the occupancy.
    always_comb begin
      hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
    end

    // High-water mark register, cleared with the queue.
    always_ff @(posedge clock) begin
      if (!reset) begin
        hwm_q <= '0;
      end else begin
        hwm_q <= hwm_d;
      end
    end

    assign hwm_o = hwm_q;
`endif
  end

endmodule

// File: rtl/tl_buffer_queue.sv
// TileLink-UL buffer: independent A (up->down) and D (down->up) FIFOs of configurable depth.
// Latency: 1 cycle per buffered channel, 0 for a depth-0 channel (combinational passthrough).
// Backpressure: enqueue ready depends only on registered occupancy; optional TL_BUFFER_QUEUE_STATS_EN adds a_hwm/d_hwm.
module tl_buffer_queue
  import tl_buffer_queue_pkg::*;
#(
  parameter int A_DEPTH  = 2,
  parameter int D_DEPTH  = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int SOURCE_W = 6
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     auto_in_a_valid,
  output logic                                     auto_in_a_ready,
  input  logic [a_w(ADDR_W, DATA_W, SOURCE_W)-1:0] auto_in_a_bits,
  output logic                                     auto_out_a_valid,
  input  logic                                     auto_out_a_ready,
  output logic [a_w(ADDR_W, DATA_W, SOURCE_W)-1:0] auto_out_a_bits,
  input  logic                                     auto_out_d_valid,
  output logic                                     auto_out_d_ready,
  input  logic [d_w(DATA_W, SOURCE_W)-1:0]         auto_out_d_bits,
  output logic                                     auto_in_d_valid,
  input  logic                                     auto_in_d_ready,
  output logic [d_w(DATA_W, SOURCE_W)-1:0]         auto_in_d_bits,
  output logic [CNT_W-1:0]                         a_count,
  output logic [CNT_W-1:0]                         d_count
`ifdef TL_BUFFER_QUEUE_STATS_EN
  ,
  output logic [CNT_W-1:0]                         a_hwm,
  output logic [CNT_W-1:0]                         d_hwm
`endif
);

  localparam int A_W = a_w(ADDR_W, DATA_W, SOURCE_W);
  localparam int D_W = d_w(DATA_W, SOURCE_W);

  tl_queue #(
    .WIDTH (A_W),
    .DEPTH (A_DEPTH)
  ) u_a_queue (
    .clock       (clock),
    .reset       (reset),
    .enq_valid_i (auto_in_a_valid),
    .enq_ready_o (auto_in_a_ready),
    .enq_bits_i  (auto_in_a_bits),
    .deq_valid_o (auto_out_a_valid),
    .deq_ready_i (auto_out_a_ready),
    .deq_bits_o  (auto_out_a_bits),
    .count_o     (a_count)
`ifdef TL_BUFFER_QUEUE_STATS_EN
    ,
    .hwm_o       (a_hwm)
`endif
  );

  tl_queue #(
    .WIDTH (D_W),
    .DEPTH (D_DEPTH)
  ) u_d_queue (
    .clock       (clock),
    .reset       (reset),
    .enq_valid_i (auto_out_d_valid),
    .enq_ready_o (auto_out_d_ready),
    .enq_bits_i  (auto_out_d_bits),
    .deq_valid_o (auto_in_d_valid),
    .deq_ready_i (auto_in_d_ready),
    .deq_bits_o  (auto_in_d_bits),
    .count_o     (d_count)
`ifdef TL_BUFFER_QUEUE_STATS_EN
    ,
    .hwm_o       (d_hwm)
`endif
  );

endmodule

// File: tb/tb_tl_buffer_queue.sv
// Bench for tl_buffer_queue: buffered instance (A depth 2, D depth 4) plus a depth-0 passthrough instance.
// Reference model is a bounded queue per channel; a negedge monitor compares DUT against it.
// Directed phases cover reset, stall/fill, full throughput, mid-drain reset; then random traffic.
`timescale 1ns/1ps
module tb_tl_buffer_queue;
  import tl_buffer_queue_pkg::*;

  localparam int ADDR_W = 32, DATA_W = 64, SOURCE_W = 6;
  localparam int A_W = a_w(ADDR_W, DATA_W, SOURCE_W);
  localparam int D_W = d_w(DATA_W, SOURCE_W);
  localparam int A_N = 2;
  localparam int D_N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_vld = 1'b0, a_out_rdy = 1'b0, d_vld = 1'b0, d_in_rdy = 1'b0;
  logic [A_W-1:0] a_bits = '0;
  logic [D_W-1:0] d_bits = '0;

  logic           a_rdy, oa_vld, od_rdy, id_vld;
  logic [A_W-1:0] oa_bits;
  logic [D_W-1:0] id_bits;
  logic [4:0]     a_cnt, d_cnt;
  logic           z_a_rdy, z_oa_vld, z_od_rdy, z_id_vld;
  logic [A_W-1:0] z_oa_bits;
  logic [D_W-1:0] z_id_bits;
  logic [4:0]     z_a_cnt, z_d_cnt;
`ifdef TL_BUFFER_QUEUE_STATS_EN
  logic [4:0]     a_hwm_w, d_hwm_w, z_a_hwm_w, z_d_hwm_w;
`endif

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  tl_buffer_queue #(.A_DEPTH(A_N), .D_DEPTH(D_N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SOURCE_W(SOURCE_W)) dut (
    .clock(clk), .reset(rst_n),
    .auto_in_a_valid(a_vld), .auto_in_a_ready(a_rdy), .auto_in_a_bits(a_bits),
    .auto_out_a_valid(oa_vld), .auto_out_a_ready(a_out_rdy), .auto_out_a_bits(oa_bits),
    .auto_out_d_valid(d_vld), .auto_out_d_ready(od_rdy), .auto_out_d_bits(d_bits),
    .auto_in_d_valid(id_vld), .auto_in_d_ready(d_in_rdy), .auto_in_d_bits(id_bits),
    .a_count(a_cnt), .d_count(d_cnt)
`ifdef TL_BUFFER_QUEUE_STATS_EN
    , .a_hwm(a_hwm_w), .d_hwm(d_hwm_w)
`endif
  );

  tl_buffer_queue #(.A_DEPTH(0), .D_DEPTH(0), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SOURCE_W(SOURCE_W)) dut0 (
    .clock(clk), .reset(rst_n),
    .auto_in_a_valid(a_vld), .auto_in_a_ready(z_a_rdy), .auto_in_a_bits(a_bits),
    .auto_out_a_valid(z_oa_vld), .auto_out_a_ready(a_out_rdy), .auto_out_a_bits(z_oa_bits),
    .auto_out_d_valid(d_vld), .auto_out_d_ready(z_od_rdy), .auto_out_d_bits(d_bits),
    .auto_in_d_valid(z_id_vld), .auto_in_d_ready(d_in_rdy), .auto_in_d_bits(z_id_bits),
    .a_count(z_a_cnt), .d_count(z_d_cnt)
`ifdef TL_BUFFER_QUEUE_STATS_EN
    , .a_hwm(z_a_hwm_w), .d_hwm(z_d_hwm_w)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [A_W-1:0] mk_a(input logic [5:0] src);
    return {3'($urandom_range(0, 5)), 3'($urandom), 4'($urandom), src, 32'($urandom),
            8'($urandom), $urandom, $urandom, 1'($urandom)};
  endfunction

  function automatic logic [D_W-1:0] mk_d(input logic [63:0] data);
    return {3'($urandom_range(0, 2)), 2'($urandom), 4'($urandom), 6'($urandom),
            1'($urandom), 1'($urandom), data, 1'($urandom)};
  endfunction

  // Reference model state: bounded FIFOs plus peak occupancy since reset.
  logic [A_W-1:0] aq[$];
  logic [D_W-1:0] dq[$];
  int a_peak = 0, d_peak = 0;

  // Scoreboard monitor: compare at negedge, then apply the upcoming edge's transfers to the model.
  always @(negedge clk) begin : mon
    bit a_enq, a_deq, d_enq, d_deq;
    if (chk_en) begin
      chk("a_in_ready", a_rdy, aq.size() < A_N);
      chk("a_out_valid", oa_vld, aq.size() != 0);
      chk("a_count", a_cnt, aq.size());
      if (oa_vld && aq.size() != 0) chk("a_out_bits", oa_bits, aq[0]);
      chk("d_out_ready", od_rdy, dq.size() < D_N);
      chk("d_in_valid", id_vld, dq.size() != 0);
      chk("d_count", d_cnt, dq.size());
      if (id_vld && dq.size() != 0) chk("d_in_bits", id_bits, dq[0]);
`ifdef TL_BUFFER_QUEUE_STATS_EN
      chk("a_hwm", a_hwm_w, a_peak);
      chk("d_hwm", d_hwm_w, d_peak);
`endif
      chk("z_a_valid", z_oa_vld, a_vld);
      chk("z_a_bits", z_oa_bits, a_bits);
      chk("z_a_ready", z_a_rdy, a_out_rdy);
      chk("z_a_count", z_a_cnt, 0);
      chk("z_d_valid", z_id_vld, d_vld);
      chk("z_d_bits", z_id_bits, d_bits);
      chk("z_d_ready", z_od_rdy, d_in_rdy);
      chk("z_d_count", z_d_cnt, 0);

      a_enq = a_vld && (aq.size() < A_N);
      a_deq = a_out_rdy && (aq.size() != 0);
      d_enq = d_vld && (dq.size() < D_N);
      d_deq = d_in_rdy && (dq.size() != 0);
      if (!rst_n) begin
        aq.delete();
        dq.delete();
        a_peak = 0;
        d_peak = 0;
      end else begin
        if (a_deq) void'(aq.pop_front());
        if (a_enq) aq.push_back(a_bits);
        if (d_deq) void'(dq.pop_front());
        if (d_enq) dq.push_back(d_bits);
        if (aq.size() > a_peak) a_peak = aq.size();
        if (dq.size() > d_peak) d_peak = dq.size();
      end
    end
  end

  // Driver-side beat queues; a beat leaves only once the DUT has taken it.
  logic [A_W-1:0] a_pend[$];
  logic [D_W-1:0] d_pend[$];
  bit a_took = 1'b0, d_took = 1'b0;

  // Record which upstream beats were accepted on this edge.
  always @(posedge clk) begin
    a_took = rst_n && a_vld && a_rdy;
    d_took = rst_n && d_vld && od_rdy;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    if (a_took && a_pend.size() != 0) void'(a_pend.pop_front());
    if (d_took && d_pend.size() != 0) void'(d_pend.pop_front());
    a_vld = (a_pend.size() != 0);
    if (a_vld) a_bits = a_pend[0];
    d_vld = (d_pend.size() != 0);
    if (d_vld) d_bits = d_pend[0];
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    rst_n = 1'b1;
    cycle();
    chk("rst_a_ready", a_rdy, 1);
    chk("rst_a_out_valid", oa_vld, 0);
    chk("rst_a_count", a_cnt, 0);

    // Stall A with downstream not ready: third beat must wait.
    a_out_rdy = 1'b0;
    for (int s = 1; s <= 3; s++) a_pend.push_back(mk_a(6'(s)));
    repeat (5) cycle();
    chk("a_stall_count", a_cnt, 2);
    chk("a_stall_ready", a_rdy, 0);
    chk("a_stall_pending", a_pend.size(), 1);
    a_out_rdy = 1'b1;
    repeat (6) cycle();
    chk("a_stall_drained", a_cnt, 0);

    // Back-to-back A traffic: one beat per cycle, occupancy steady at 1.
    for (int k = 0; k < 20; k++) a_pend.push_back(mk_a(6'($urandom)));
    repeat (4) cycle();
    chk("a_tput_count", a_cnt, 1);
    repeat (17) cycle();
    chk("a_tput_pending", a_pend.size(), 0);
    chk("a_tput_count_end", a_cnt, 1);
    repeat (2) cycle();
    chk("a_tput_drained", a_cnt, 0);

    // Fill D with 0xA..0xD, pop one, then reset mid-drain.
    d_in_rdy = 1'b0;
    for (int k = 10; k <= 13; k++) d_pend.push_back(mk_d(64'(k)));
    repeat (7) cycle();
    chk("d_full_count", d_cnt, 4);
    chk("d_full_ready", od_rdy, 0);
    d_in_rdy = 1'b1;
    cycle();
    chk("d_drain_count", d_cnt, 3);
    rst_n = 1'b0;
    d_pend.delete();
    cycle();
    rst_n = 1'b1;
    chk("d_rst_valid", id_vld, 0);
    chk("d_rst_count", d_cnt, 0);
    repeat (3) cycle();
    chk("d_rst_no_stale", id_vld, 0);

    // Peak of three in D, then drain; the model tracks the high-water mark.
    d_in_rdy = 1'b0;
    for (int k = 0; k < 3; k++) d_pend.push_back(mk_d({$urandom, $urandom}));
    repeat (6) cycle();
    chk("d_peak_count", d_cnt, 3);
    d_in_rdy = 1'b1;
    repeat (6) cycle();
    chk("d_peak_drained", d_cnt, 0);
`ifdef TL_BUFFER_QUEUE_STATS_EN
    chk("d_hwm_retained", d_hwm_w, 3);
`endif

    // Random traffic with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      a_out_rdy = ($urandom_range(0, 3) != 0);
      d_in_rdy  = ($urandom_range(0, 3) != 0);
      if (a_pend.size() < 3 && $urandom_range(0, 2) != 0) a_pend.push_back(mk_a(6'($urandom)));
      if (d_pend.size() < 3 && $urandom_range(0, 2) != 0) d_pend.push_back(mk_d({$urandom, $urandom}));
      if (i == 200) begin
        rst_n = 1'b0;
        a_pend.delete();
        d_pend.delete();
      end else begin
        rst_n = 1'b1;
      end
      cycle();
    end
    rst_n = 1'b1;
    a_out_rdy = 1'b1;
    d_in_rdy = 1'b1;
    repeat (20) cycle();
    chk("final_a_count", a_cnt, 0);
    chk("final_d_count", d_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, time %0t limit 1000000", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
